// File: rtl/bridge_dataslot_loader.sv
// Loads one APF dataslot into core memory once the host has finished writing dataslots.
// Latency: trigger->read 1 cycle, ack->read low 1 cycle, done->load_done 1 cycle; 16-cycle backoff between retries.
// Backpressure: read is held until APF acks; optional watchdog (BRIDGE_DATASLOT_LOADER_TIMEOUT_EN) bounds the wait.
module bridge_dataslot_loader #(
  parameter logic [15:0] SLOT_ID           = 16'd0,
  parameter logic [31:0] DEST_ADDR         = 32'h0000_0000,
  parameter logic [31:0] LOAD_LENGTH       = 32'h0000_0000,
  parameter logic [31:0] SLOT_SIZE_DEFAULT = 32'h0000_1000,
  parameter int unsigned MAX_RETRIES       = 2,
  parameter logic [23:0] TIMEOUT_CYCLES    = 24'hFF_FFFF
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        slot_base_found,
  input  logic        slot_size_zero,
  input  logic        dataslot_allcomplete,
  output logic        target_dataslot_read,
  output logic [15:0] target_dataslot_id,
  output logic [31:0] target_dataslot_slotoffset,
  output logic [31:0] target_dataslot_bridgeaddr,
  output logic [31:0] target_dataslot_length,
  input  logic        target_dataslot_ack,
  input  logic        target_dataslot_done,
  input  logic [2:0]  target_dataslot_err,
  output logic        load_busy,
  output logic        load_done,
  output logic        load_skipped,
  output logic        load_error,
  output logic [2:0]  load_err_code
);

  typedef enum logic [2:0] {
    S_IDLE, S_SKIP, S_REQ, S_WAIT_DONE, S_BACKOFF, S_FINISHED
  } state_t;

  localparam logic [31:0] LEN       = (LOAD_LENGTH != 32'd0) ? LOAD_LENGTH : SLOT_SIZE_DEFAULT;
  localparam logic [2:0]  MAX_RETRY = 3'(MAX_RETRIES);

  state_t      state_q, state_d;
  logic        done_q, done_d;
  logic        skipped_q, skipped_d;
  logic        error_q, error_d;
  logic [2:0]  err_code_q, err_code_d;
  logic [2:0]  retry_q, retry_d;
  logic [3:0]  backoff_q, backoff_d;
  logic        in_cmd;
  logic        timeout;
  logic        cmd_done;
  logic [2:0]  cmd_err;

  assign in_cmd = (state_q == S_REQ) || (state_q == S_WAIT_DONE);

`ifdef BRIDGE_DATASLOT_LOADER_TIMEOUT_EN
  logic [23:0] wdog_q, wdog_d;

  // Watchdog: counts cycles spent waiting on APF, zero whenever no command is outstanding
  always_comb begin
    wdog_d  = in_cmd ? (wdog_q + 24'd1) : 24'd0;
    timeout = in_cmd && ((wdog_q + 24'd1) == TIMEOUT_CYCLES);
  end

  // Watchdog register
  always_ff @(posedge clk) begin
    if (!reset_n) wdog_q <= 24'd0;
    else          wdog_q <= wdog_d;
  end
`else
  logic unused_timeout_cycles;
  assign unused_timeout_cycles = ^TIMEOUT_CYCLES;
  assign timeout = 1'b0;
`endif

  // Next-state and status: command completion (done, or watchdog as err 7) resolved in one place
  always_comb begin
    state_d    = state_q;
    done_d     = done_q;
    skipped_d  = skipped_q;
    error_d    = error_q;
    err_code_d = err_code_q;
    retry_d    = retry_q;
    backoff_d  = 4'd0;
    cmd_done   = 1'b0;
    cmd_err    = 3'd0;
    case (state_q)
      S_IDLE: begin
        if (slot_base_found && dataslot_allcomplete)
          state_d = slot_size_zero ? S_SKIP : S_REQ;
      end
      S_SKIP: begin
        done_d    = 1'b1;
        skipped_d = 1'b1;
        state_d   = S_FINISHED;
      end
      S_REQ: begin
        if (target_dataslot_ack) begin
          // ack with done in the same cycle completes without visiting WAIT_DONE
          if (target_dataslot_done) begin
            cmd_done = 1'b1;
            cmd_err  = target_dataslot_err;
          end else begin
            state_d = S_WAIT_DONE;
          end
        end
      end
      S_WAIT_DONE: begin
        if (target_dataslot_done) begin
          cmd_done = 1'b1;
          cmd_err  = target_dataslot_err;
        end
      end
      S_BACKOFF: begin
        backoff_d = backoff_q + 4'd1;
        if (backoff_q == 4'd15) state_d = S_REQ;
      end
      S_FINISHED: begin
        // Host rewrote the slot table: forget the previous result and allow a reload
        if (!slot_base_found) begin
          done_d     = 1'b0;
          skipped_d  = 1'b0;
          error_d    = 1'b0;
          err_code_d = 3'd0;
          retry_d    = 3'd0;
          state_d    = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (!cmd_done && timeout) begin
      cmd_done = 1'b1;
      cmd_err  = 3'd7;
    end

    if (cmd_done) begin
      if (cmd_err == 3'd0) begin
        done_d  = 1'b1;
        state_d = S_FINISHED;
      end else begin
        err_code_d = cmd_err;
        if (retry_q < MAX_RETRY) begin
          retry_d = retry_q + 3'd1;
          state_d = S_BACKOFF;
        end else begin
          error_d = 1'b1;
          state_d = S_FINISHED;
        end
      end
    end
  end

  // State and status registers
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q    <= S_IDLE;
      done_q     <= 1'b0;
      skipped_q  <= 1'b0;
      error_q    <= 1'b0;
      err_code_q <= 3'd0;
      retry_q    <= 3'd0;
      backoff_q  <= 4'd0;
    end else begin
      state_q    <= state_d;
      done_q     <= done_d;
      skipped_q  <= skipped_d;
      error_q    <= error_d;
      err_code_q <= err_code_d;
      retry_q    <= retry_d;
      backoff_q  <= backoff_d;
    end
  end

  // Command fields are constants gated by the registered state, so they read 0 when idle
  assign target_dataslot_read       = (state_q == S_REQ);
  assign target_dataslot_id         = in_cmd ? SLOT_ID   : 16'd0;
  assign target_dataslot_bridgeaddr = in_cmd ? DEST_ADDR : 32'd0;
  assign target_dataslot_length     = in_cmd ? LEN       : 32'd0;
  assign target_dataslot_slotoffset = 32'd0;
  assign load_busy                  = in_cmd || (state_q == S_BACKOFF);
  assign load_done                  = done_q;
  assign load_skipped               = skipped_q;
  assign load_error                 = error_q;
  assign load_err_code              = err_code_q;

endmodule

// File: tb/tb_bridge_dataslot_loader.sv
// Self-checking bench for bridge_dataslot_loader.
// A timeline model built from the handshake rules predicts every output per cycle.
// Randomized APF ack/done delays and error codes drive each scenario.
module tb_bridge_dataslot_loader;

  localparam logic [15:0] TB_ID   = 16'hA5C3;
  localparam logic [31:0] TB_ADDR = 32'h1234_5600;
  localparam logic [31:0] TB_LEN  = 32'h0000_2400;
  localparam int          MAXR    = 2;
  localparam int          TMO     = 100;
  localparam int          MAXC    = 600;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        slot_base_found, slot_size_zero, dataslot_allcomplete;
  logic        target_dataslot_read;
  logic [15:0] target_dataslot_id;
  logic [31:0] target_dataslot_slotoffset, target_dataslot_bridgeaddr, target_dataslot_length;
  logic        target_dataslot_ack, target_dataslot_done;
  logic [2:0]  target_dataslot_err;
  logic        load_busy, load_done, load_skipped, load_error;
  logic [2:0]  load_err_code;

  int checks = 0;
  int errors = 0;

  bridge_dataslot_loader #(
    .SLOT_ID(TB_ID), .DEST_ADDR(TB_ADDR), .LOAD_LENGTH(32'd0),
    .SLOT_SIZE_DEFAULT(TB_LEN), .MAX_RETRIES(MAXR), .TIMEOUT_CYCLES(24'(TMO))
  ) dut (
    .clk(clk), .reset_n(reset_n),
    .slot_base_found(slot_base_found), .slot_size_zero(slot_size_zero),
    .dataslot_allcomplete(dataslot_allcomplete),
    .target_dataslot_read(target_dataslot_read), .target_dataslot_id(target_dataslot_id),
    .target_dataslot_slotoffset(target_dataslot_slotoffset),
    .target_dataslot_bridgeaddr(target_dataslot_bridgeaddr),
    .target_dataslot_length(target_dataslot_length),
    .target_dataslot_ack(target_dataslot_ack), .target_dataslot_done(target_dataslot_done),
    .target_dataslot_err(target_dataslot_err),
    .load_busy(load_busy), .load_done(load_done), .load_skipped(load_skipped),
    .load_error(load_error), .load_err_code(load_err_code)
  );

  always #5 clk = ~clk;

  // Attempt plan: cycles from read rising to ack, cycles from ack to done, error code
  int   n_att;
  int   a_ack[8];
  int   a_dly[8];
  int   a_err[8];
  bit   a_noack[8];

  // Expected outputs and driven stimulus, indexed by edge number after the trigger
  bit       e_read[MAXC], e_cmd[MAXC], e_busy[MAXC], e_done[MAXC], e_skip[MAXC], e_error[MAXC];
  logic [2:0] e_code[MAXC];
  bit       s_ack[MAXC], s_done[MAXC];
  logic [2:0] s_err[MAXC];

  task automatic do_reset();
    reset_n = 1'b0; slot_base_found = 1'b0; slot_size_zero = 1'b0; dataslot_allcomplete = 1'b0;
    target_dataslot_ack = 1'b0; target_dataslot_done = 1'b0; target_dataslot_err = 3'd0;
    @(posedge clk); @(posedge clk); #1;
    reset_n = 1'b1;
  endtask

  // Build the expected timeline from the plan, then drive it and compare every cycle
  task automatic run_load(input string name, input bit size_zero);
    int r, e, retries, res, last_rd, n_cyc;
    logic [7:0]   obs, expv;
    logic [111:0] cobs, cexp;
    for (int k = 0; k < MAXC; k++) begin
      e_read[k] = 0; e_cmd[k] = 0; e_busy[k] = 0; e_done[k] = 0; e_skip[k] = 0;
      e_error[k] = 0; e_code[k] = 3'd0; s_ack[k] = 0; s_done[k] = 0; s_err[k] = 3'd0;
    end
    if (size_zero) begin
      for (int k = 2; k < MAXC; k++) begin e_done[k] = 1; e_skip[k] = 1; end
      n_cyc = 10;
    end else begin
      r = 1; e = 1; retries = 0;
      for (int i = 0; i < n_att; i++) begin
        if (a_noack[i]) begin
          e = r + TMO; last_rd = e - 1; res = 7;
        end else begin
          e = r + a_ack[i] + 1 + a_dly[i]; last_rd = r + a_ack[i]; res = a_err[i];
          s_ack[r + a_ack[i] + 1] = 1;
          if (a_dly[i] >= 2) s_ack[e - 1] = 1;  // stray ack while waiting for done
          s_done[e] = 1; s_err[e] = 3'(a_err[i]);
        end
        for (int k = r; k < e; k++) begin e_cmd[k] = 1; e_busy[k] = 1; end
        for (int k = r; k <= last_rd; k++) e_read[k] = 1;
        if (res == 0) begin
          for (int k = e; k < MAXC; k++) e_done[k] = 1;
          break;
        end
        for (int k = e; k < MAXC; k++) e_code[k] = 3'(res);
        if (retries < MAXR) begin
          retries++;
          for (int k = e; k < e + 16; k++) e_busy[k] = 1;
          r = e + 16;
        end else begin
          for (int k = e; k < MAXC; k++) e_error[k] = 1;
          break;
        end
      end
      n_cyc = e + 6;
    end

    slot_base_found = 1'b1; dataslot_allcomplete = 1'b1; slot_size_zero = size_zero;
    for (int k = 1; k <= n_cyc; k++) begin
      target_dataslot_ack  = s_ack[k];
      target_dataslot_done = s_done[k];
      target_dataslot_err  = s_done[k] ? s_err[k] : 3'($urandom);
      @(posedge clk); #1;
      obs  = {target_dataslot_read, load_busy, load_done, load_skipped, load_error, load_err_code};
      expv = {e_read[k], e_busy[k], e_done[k], e_skip[k], e_error[k], e_code[k]};
      checks++;
      if (obs !== expv) begin
        errors++;
        $display("FAIL %s cycle %0d read/busy/done/skip/error/code got %b want %b", name, k, obs, expv);
      end
      cobs = {target_dataslot_id, target_dataslot_bridgeaddr, target_dataslot_length, target_dataslot_slotoffset};
      cexp = e_cmd[k] ? {TB_ID, TB_ADDR, TB_LEN, 32'h0} : 112'h0;
      checks++;
      if (cobs !== cexp) begin
        errors++;
        $display("FAIL %s_cmd cycle %0d id/addr/len/off got %h want %h", name, k, cobs, cexp);
      end
    end
    target_dataslot_ack = 1'b0; target_dataslot_done = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if ({target_dataslot_read, load_busy, load_done, load_skipped, load_error, load_err_code,
         target_dataslot_id, target_dataslot_bridgeaddr, target_dataslot_length} !== 88'h0) begin
      errors++;
      $display("FAIL reset outputs got read=%b busy=%b done=%b err_code=%0d want all 0",
               target_dataslot_read, load_busy, load_done, load_err_code);
    end
  endtask

  task automatic test_idle_no_trigger();
    do_reset();
    for (int k = 0; k < 30; k++) begin
      slot_base_found      = 1'($urandom);
      dataslot_allcomplete = slot_base_found ? 1'b0 : 1'($urandom);
      slot_size_zero       = 1'($urandom);
      target_dataslot_ack  = 1'($urandom);
      target_dataslot_done = 1'($urandom);
      @(posedge clk); #1;
      checks++;
      if ({target_dataslot_read, load_busy, load_done, load_skipped, load_error} !== 5'b0) begin
        errors++;
        $display("FAIL idle_no_trigger cycle %0d got %b want 00000", k,
                 {target_dataslot_read, load_busy, load_done, load_skipped, load_error});
      end
    end
    target_dataslot_ack = 1'b0; target_dataslot_done = 1'b0;
  endtask

  task automatic test_load_ok();
    do_reset();
    n_att = 1; a_noack[0] = 0; a_ack[0] = 3; a_dly[0] = 10; a_err[0] = 0;
    run_load("load_ok_fixed", 1'b0);
    for (int t = 0; t < 3; t++) begin
      do_reset();
      a_ack[0] = $urandom_range(0, 6); a_dly[0] = $urandom_range(1, 12);
      run_load("load_ok_rand", 1'b0);
    end
  endtask

  task automatic test_skip();
    do_reset();
    run_load("skip", 1'b1);
  endtask

  task automatic test_ack_done_same();
    do_reset();
    n_att = 1; a_noack[0] = 0; a_ack[0] = $urandom_range(0, 5); a_dly[0] = 0; a_err[0] = 0;
    run_load("ack_done_same", 1'b0);
    do_reset();
    n_att = 2;
    a_noack[0] = 0; a_ack[0] = 2; a_dly[0] = 0; a_err[0] = $urandom_range(1, 7);
    a_noack[1] = 0; a_ack[1] = 0; a_dly[1] = 0; a_err[1] = 0;
    run_load("ack_done_same_err", 1'b0);
  endtask

  task automatic test_retry_exhaust();
    do_reset();
    n_att = 3;
    for (int i = 0; i < 3; i++) begin
      a_noack[i] = 0; a_ack[i] = $urandom_range(0, 5); a_dly[i] = $urandom_range(0, 8); a_err[i] = 3;
    end
    run_load("retry_exhaust", 1'b0);
  endtask

  task automatic test_retry_recover();
    int nerr;
    for (int t = 0; t < 2; t++) begin
      do_reset();
      nerr = $urandom_range(1, 2);
      n_att = nerr + 1;
      for (int i = 0; i <= nerr; i++) begin
        a_noack[i] = 0; a_ack[i] = $urandom_range(0, 5); a_dly[i] = $urandom_range(0, 8);
        a_err[i] = (i == nerr) ? 0 : $urandom_range(1, 7);
      end
      run_load("retry_recover", 1'b0);
    end
  endtask

  task automatic test_reload();
    do_reset();
    n_att = 3;
    for (int i = 0; i < 3; i++) begin
      a_noack[i] = 0; a_ack[i] = $urandom_range(0, 4); a_dly[i] = $urandom_range(0, 6);
      a_err[i] = $urandom_range(1, 7);
    end
    run_load("reload_first", 1'b0);
    slot_base_found = 1'b0;
    @(posedge clk); #1;
    checks++;
    if ({load_busy, load_done, load_skipped, load_error, load_err_code} !== 7'b0) begin
      errors++;
      $display("FAIL reload_clear got busy/done/skip/error/code %b want 0000000",
               {load_busy, load_done, load_skipped, load_error, load_err_code});
    end
    // Two errors then success only fits if the retry count was cleared
    n_att = 3;
    for (int i = 0; i < 3; i++) begin
      a_noack[i] = 0; a_ack[i] = $urandom_range(0, 4); a_dly[i] = $urandom_range(0, 6);
      a_err[i] = (i == 2) ? 0 : $urandom_range(1, 7);
    end
    run_load("reload_second", 1'b0);
  endtask

  task automatic test_reset_midflight();
    do_reset();
    slot_base_found = 1'b1; dataslot_allcomplete = 1'b1;
    @(posedge clk); #1;
    target_dataslot_ack = 1'b1;
    @(posedge clk); #1;
    target_dataslot_ack = 1'b0;
    checks++;
    if ({target_dataslot_read, load_busy} !== 2'b01) begin
      errors++;
      $display("FAIL midflight_wait got read/busy %b want 01", {target_dataslot_read, load_busy});
    end
    reset_n = 1'b0; slot_base_found = 1'b0;
    @(posedge clk); #1;
    checks++;
    if ({target_dataslot_read, load_busy, load_done, load_skipped, load_error, load_err_code,
         target_dataslot_id, target_dataslot_bridgeaddr, target_dataslot_length} !== 88'h0) begin
      errors++;
      $display("FAIL midflight_reset got read=%b busy=%b id=%h want all 0",
               target_dataslot_read, load_busy, target_dataslot_id);
    end
    reset_n = 1'b1;
    target_dataslot_done = 1'b1;  // late done from the abandoned command must not matter
    @(posedge clk); #1;
    target_dataslot_done = 1'b0;
    checks++;
    if ({target_dataslot_read, load_busy, load_done, load_error} !== 4'b0) begin
      errors++;
      $display("FAIL midflight_idle got %b want 0000",
               {target_dataslot_read, load_busy, load_done, load_error});
    end
    n_att = 1; a_noack[0] = 0; a_ack[0] = 1; a_dly[0] = 3; a_err[0] = 0;
    run_load("after_midflight", 1'b0);
  endtask

`ifdef BRIDGE_DATASLOT_LOADER_TIMEOUT_EN
  task automatic test_timeout();
    do_reset();
    n_att = 3;
    for (int i = 0; i < 3; i++) a_noack[i] = 1;
    run_load("timeout", 1'b0);
  endtask
`else
  task automatic test_wait_forever();
    do_reset();
    slot_base_found = 1'b1; dataslot_allcomplete = 1'b1;
    for (int k = 1; k <= 300; k++) begin
      @(posedge clk); #1;
      checks++;
      if ({target_dataslot_read, load_busy, load_error, load_err_code} !== 6'b110000) begin
        errors++;
        $display("FAIL wait_forever cycle %0d read/busy/error/code got %b want 110000", k,
                 {target_dataslot_read, load_busy, load_error, load_err_code});
      end
    end
  endtask
`endif

  initial begin
    test_reset();
    test_idle_no_trigger();
    test_load_ok();
    test_skip();
    test_ack_done_same();
    test_retry_exhaust();
    test_retry_recover();
    test_reload();
    test_reset_midflight();
`ifdef BRIDGE_DATASLOT_LOADER_TIMEOUT_EN
    test_timeout();
`else
    test_wait_forever();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_time_limit reached checks=%0d errors=%0d", checks, errors);
    $fatal(1);
  end

endmodule

// File: doc/bridge_dataslot_loader.md
Name: bridge_dataslot_loader

Overview:
- Sits directly downstream of the dataslot find-and-replace stage and consumes its slot_base_found / slot_size_zero results.
- Once the host has written every dataslot, issues one target_dataslot_read command so APF copies slot SLOT_ID into core memory at DEST_ADDR.
- Drives the command handshake (req/ack/done/err), retries on error and reports busy/done/skip/error status to the core.

Parameters:
- SLOT_ID, 0, dataslot ID to load (16 bits).
- DEST_ADDR, 32'h0000_0000, bridge address APF writes the slot data to.
- LOAD_LENGTH, 32'h0000_0000, byte count requested; 0 means load SLOT_SIZE_DEFAULT.
- SLOT_SIZE_DEFAULT, 32'h0000_1000, length used when LOAD_LENGTH is 0.
- MAX_RETRIES, 2, retries after an error before giving up (0..7).
- TIMEOUT_CYCLES, 24'hFF_FFFF, watchdog limit; used only with the optional feature.

Ports:
- clk  in  1  bridge clock.
- reset_n  in  1  synchronous active-low reset.
- slot_base_found  in  1  level from the finder; slot entry seen.
- slot_size_zero  in  1  level from the finder; slot written with size 0.
- dataslot_allcomplete  in  1  host has finished dataslot writes.
- target_dataslot_read  out  1  command request, held until ack.
- target_dataslot_id  out  16  command slot ID.
- target_dataslot_slotoffset  out  32  offset into slot; always 0.
- target_dataslot_bridgeaddr  out  32  destination address.
- target_dataslot_length  out  32  byte count.
- target_dataslot_ack  in  1  APF accepted the command.
- target_dataslot_done  in  1  APF finished the command.
- target_dataslot_err  in  3  error code, valid with done.
- load_busy  out  1  command in flight.
- load_done  out  1  sticky; load succeeded or was skipped.
- load_skipped  out  1  sticky; slot size was 0, no command issued.
- load_error  out  1  sticky; retries exhausted.
- load_err_code  out  3  last nonzero err, or 3'd7 on timeout.

Behaviour:
- Reset (reset_n low at clk edge):
  - All outputs 0, state IDLE, retry counter 0, watchdog counter 0.
  - Takes effect from any state. A command already in flight is abandoned; the block does not wait for done.
- id, bridgeaddr and length are registered constants. They are driven only while state is REQ or WAIT_DONE and are 0 otherwise.
- IDLE:
  - When slot_base_found && dataslot_allcomplete are both high and slot_size_zero is 0, go to REQ on the next cycle.
  - When both are high and slot_size_zero is 1, go to SKIP.
  - dataslot_allcomplete alone (slot never found): stay in IDLE; no output changes.
- SKIP: one cycle. Sets load_done=1 and load_skipped=1, then goes to FINISHED.
- REQ:
  - target_dataslot_read=1 and load_busy=1.
  - On the cycle ack is sampled high, drop read on the next edge and go to WAIT_DONE.
  - If ack and done are high in the same cycle, treat it as ack followed by done and evaluate done immediately; do not enter WAIT_DONE.
- WAIT_DONE:
  - read=0, load_busy=1. Any ack arriving here is ignored.
  - On done with err==0: load_done=1, go to FINISHED.
  - On done with err!=0: load_err_code=err.
    - If retry counter < MAX_RETRIES: increment the counter, go to BACKOFF.
    - Otherwise: load_error=1, go to FINISHED.
- BACKOFF: 16-cycle counter, then back to REQ. load_busy stays 1.
- FINISHED:
  - load_busy=0; status flags are held.
  - When slot_base_found falls (host rewrote the table), clear load_done, load_skipped, load_error, load_err_code and the retry counter, and go to IDLE. A reload is then allowed.
- Latency: IDLE trigger to read=1 is 1 cycle. read falls 1 cycle after ack. load_done rises 1 cycle after done.
- Simultaneous events: a slot_base_found fall while in REQ, WAIT_DONE or BACKOFF is ignored until FINISHED, where it is evaluated normally.
- Length selection: LOAD_LENGTH if nonzero, else SLOT_SIZE_DEFAULT; fixed at elaboration.

Optional Feature:
- BRIDGE_DATASLOT_LOADER_TIMEOUT_EN defined:
  - A 24-bit watchdog counts cycles spent in REQ+WAIT_DONE and is cleared on entry to REQ.
  - On reaching TIMEOUT_CYCLES: load_err_code=3'd7, then the normal error/retry path is taken as if done arrived with err=7.
- Undefined: no watchdog logic is built. The block waits forever for ack/done, and load_err_code never takes 7 from a timeout.

Test Plan:
- Found=1, size_zero=0, allcomplete=1; ack after 3 cycles; done err=0 after 10 more -> read high 1 cycle after trigger, id=SLOT_ID, bridgeaddr=DEST_ADDR, read low 1 cycle after ack, load_done=1, load_busy=0.
- Found=1, size_zero=1, allcomplete=1 -> no read ever asserted, load_done=1 and load_skipped=1 after 2 cycles.
- MAX_RETRIES=2; done with err=3 on three consecutive attempts -> 3 read assertions spaced by the 16-cycle backoff, then load_error=1 and load_err_code=3.
- Ack and done (err=0) in the same cycle -> load_done=1 next cycle, no WAIT_DONE state.
- Finish a load, drop found, raise found again -> flags clear, second command issued; reset_n pulsed low during WAIT_DONE -> all outputs 0 next cycle, state IDLE.
- With BRIDGE_DATASLOT_LOADER_TIMEOUT_EN, TIMEOUT_CYCLES=100, MAX_RETRIES=0, ack never given -> after 100 cycles load_error=1 and load_err_code=7.
